axi_wdata_dest_router: RTL and testbench
========================================

# axi_wdata_dest_router

Write-data routing stage placed directly downstream of the AW address decoder in the AXI4 interconnect node. It stores the one-hot destination of every accepted AW burst in a small FIFO. It steers W beats to the matching initiator port in burst order and pops on the last beat. When the decoder signals an error, it sinks the W beats of the erroneous burst and reports completion.

## Interface
Parameters:
- N_INIT_PORT, 8, number of initiator (downstream) ports; width of destination vectors
- FIFO_DEPTH, 4, destination FIFO entries; must be power of two, ≥2

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- push_dest_i  in  1  decoder pushes one destination (AW handshake, no error)
- dest_i  in  N_INIT_PORT  destination of pushed burst, expected one-hot
- grant_fifo_dest_o  out  1  FIFO can accept a push (not full)
- wvalid_i  in  1  W beat valid from target side
- wlast_i  in  1  last beat of burst
- wready_o  out  1  W beat accepted
- wvalid_o  out  N_INIT_PORT  per-initiator W valid
- wready_i  in  N_INIT_PORT  per-initiator W ready
- handle_error_i  in  1  decoder requests draining of an error burst
- wdata_error_completed_o  out  1  last beat of error burst consumed (single-cycle pulse)

## Operation
- Push: when push_dest_i=1, dest_i is written at the write pointer. Multi-hot dest_i is reduced to its lowest set bit before storage. Zero dest_i is stored as is, and that burst will never be routed; the bench flags this as a fault.
- Head: when the FIFO is non-empty, the head entry selects the port:
  - wvalid_o[k] = wvalid_i & head[k]
  - wready_o = |(wready_i & head)
- Pop: on wvalid_i & wready_o & wlast_i while routing. Non-last beats do not pop.
- FSM states:
  - ROUTE (reset state): routing as above.
  - DRAIN: wready_o=1 and wvalid_o=0.
- ROUTE→DRAIN: handle_error_i=1 and the FIFO is empty. Earlier bursts always finish first. With a non-empty FIFO, handle_error_i is held pending.
- DRAIN→ROUTE: wvalid_i & wlast_i. In that cycle wdata_error_completed_o=1; it is combinational and 0 in every other cycle.
- Pushes during DRAIN are accepted into the FIFO (the decoder does not issue them).
- Occupancy uses a count of log2(FIFO_DEPTH)+1 bits; pointers wrap modulo FIFO_DEPTH.

## Timing
- Reset values: grant_fifo_dest_o=1, wready_o=0, wvalid_o=0, wdata_error_completed_o=0, FSM=ROUTE, pointers and count=0.
- grant_fifo_dest_o is driven from the registered count only: it is 0 exactly when count==FIFO_DEPTH. A same-cycle pop does not re-open the grant.
- A push while full is ignored and covered by an assertion.
- Push latency: without bypass, a pushed destination reaches the head on the next cycle.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Zero-cycle data path: wvalid_o and wready_o are combinational from inputs, head and state. There are no registers on W.
- Reset asserted mid-burst clears all state immediately and discards queued destinations.
- handle_error_i is deasserted by the decoder on the cycle after the completion pulse. DRAIN is not re-entered because the FSM is back in ROUTE and the decoder has left its error-accept state.

## Configuration
- AXI_WDATA_DEST_BYPASS_EN defined: a push into an empty FIFO drives the head the same cycle. If the same cycle also carries a last-beat handshake, the entry is consumed without being stored (count stays 0).
- AXI_WDATA_DEST_BYPASS_EN undefined: one-cycle push-to-head latency as above.

## Structure
- The shared package axi_node_pkg holds:
  - the FSM enum type (ROUTE, DRAIN), 1 bit
  - the clog2-based pointer width function
- Sub-module axi_dest_fifo: generic registered FIFO with push/pop/full/empty/head, parameterised width and depth, containing the bypass path under the macro.
- The top level contains the one-hot reduction, steering logic and FSM.

## Test plan
- Reset, then push dest=8'b0000_0100, then a 4-beat burst with wready_i=all 1s → only wvalid_o[2] toggles, wready_o=1 on each beat, FIFO empty after beat 4.
- Push FIFO_DEPTH=4 entries with no W traffic → grant_fifo_dest_o=0 after the 4th push; a 5th push is ignored; one last-beat pop → grant_fifo_dest_o=1 the next cycle.
- Push dest=8'b0000_0110 → burst routed to port 1 only.
- One entry queued, handle_error_i=1 → the queued burst completes to its port first, then DRAIN. A 3-beat error burst gets wready_o=1 and wvalid_o=0; wdata_error_completed_o is high only on beat 3.
- Backpressure: wready_i[5]=0 for 3 cycles on a port-5 burst → wready_o=0 for those cycles, no pop, beats delivered in order.
- Assert rst_n=0 in the middle of a burst with 2 entries queued → all outputs return to reset values and the FIFO reads empty after release. With AXI_WDATA_DEST_BYPASS_EN, push plus a single-beat last on an empty FIFO in one cycle → routed the same cycle, count stays 0.

Source files
------------

// File: rtl/axi_node_pkg.sv
// Shared types and helpers for the AXI interconnect node.
// No logic of its own; zero latency.
// No flow control; used by the W-data routing stage and its destination FIFO.
//
// Contents:
//   wdata_state_e : W routing FSM state (ROUTE, DRAIN), 1 bit
//   ptr_width()   : pointer width for a FIFO of a given depth
package axi_node_pkg;

  typedef enum logic {
    ROUTE = 1'b0,
    DRAIN = 1'b1
  } wdata_state_e;

  // A depth-1 FIFO still needs a 1-bit pointer so the vector stays legal.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/axi_dest_fifo.sv
// Generic registered FIFO holding one destination vector per queued burst.
// Latency: push-to-head one cycle; zero cycles into an empty FIFO with AXI_WDATA_DEST_BYPASS_EN.
// Backpressure: full is derived from the registered count only; a push while full is dropped.
//
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   push, push_dat     : write one entry
//   pop                : consume the head entry (stored or bypassed)
//   full               : count == DEPTH
//   head_vld, head_dat : head entry present / its value
// Optional macro: AXI_WDATA_DEST_BYPASS_EN (push into an empty FIFO is visible at the head
// in the same cycle; if it is also popped in that cycle it is never stored).
module axi_dest_fifo
  import axi_node_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic             full,
  output logic             head_vld,
  output logic [WIDTH-1:0] head_dat
);

  localparam int PW = ptr_width(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             empty;
  logic             wr_en;
  logic             rd_en;

  assign empty = (count == '0);
  assign full  = (count == DEPTH_C);

`ifdef AXI_WDATA_DEST_BYPASS_EN
  assign head_vld = ~empty | push;
  assign head_dat = empty ? push_dat : mem[rd_ptr];
  // An entry pushed and consumed in the same cycle on an empty FIFO never lands in storage.
  assign wr_en    = push & ~full & ~(empty & pop);
  assign rd_en    = pop & ~empty;
`else
  assign head_vld = ~empty;
  assign head_dat = mem[rd_ptr];
  assign wr_en    = push & ~full;
  assign rd_en    = pop & ~empty;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (rd_en) rd_ptr <= rd_ptr + PW'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset: the count alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_dat;
  end

  // A push while full is dropped; occupancy must never exceed the depth.
  assert property (@(posedge clk) disable iff (!rst_n) count <= DEPTH_C);
  cover property (@(posedge clk) disable iff (!rst_n) push && full);

endmodule

// File: rtl/axi_wdata_dest_router.sv
// Steers W beats to the initiator port recorded for each AW burst; sinks W beats of error bursts.
// Latency: zero-cycle W path (combinational valid/ready); destination reaches the head one cycle after push.
// Backpressure: wready_o follows the selected port's wready_i; grant_fifo_dest_o drops when the FIFO is full.
//
// Ports:
//   clk, rst_n               : clock, asynchronous active-low reset
//   push_dest_i, dest_i      : destination of an accepted AW burst (reduced to its lowest set bit)
//   grant_fifo_dest_o        : destination FIFO not full
//   wvalid_i, wlast_i        : W beat from the target side
//   wready_o                 : W beat accepted
//   wvalid_o, wready_i       : per-initiator W handshake
//   handle_error_i           : decoder requests draining of an error burst
//   wdata_error_completed_o  : last beat of the error burst consumed (combinational pulse)
// Optional macro: AXI_WDATA_DEST_BYPASS_EN (same-cycle push-to-head on an empty FIFO).
module axi_wdata_dest_router
  import axi_node_pkg::*;
#(
  parameter int N_INIT_PORT = 8,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_dest_i,
  input  logic [N_INIT_PORT-1:0] dest_i,
  output logic                   grant_fifo_dest_o,
  input  logic                   wvalid_i,
  input  logic                   wlast_i,
  output logic                   wready_o,
  output logic [N_INIT_PORT-1:0] wvalid_o,
  input  logic [N_INIT_PORT-1:0] wready_i,
  input  logic                   handle_error_i,
  output logic                   wdata_error_completed_o
);

  logic [N_INIT_PORT-1:0] dest_low;
  logic [N_INIT_PORT-1:0] head;
  logic                   head_vld;
  logic                   fifo_full;
  logic                   pop;
  wdata_state_e           state;
  wdata_state_e           state_n;

  // x & -x isolates the lowest set bit; an all-zero destination stays zero.
  assign dest_low = dest_i & (~dest_i + N_INIT_PORT'(1));

  assign grant_fifo_dest_o = ~fifo_full;

  axi_dest_fifo #(
    .WIDTH (N_INIT_PORT),
    .DEPTH (FIFO_DEPTH)
  ) u_dest_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push_dest_i),
    .push_dat (dest_low),
    .pop      (pop),
    .full     (fifo_full),
    .head_vld (head_vld),
    .head_dat (head)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ROUTE;
    else        state <= state_n;
  end

  always_comb begin
    state_n                 = state;
    wvalid_o                = '0;
    wready_o                = 1'b0;
    pop                     = 1'b0;
    wdata_error_completed_o = 1'b0;
    case (state)
      ROUTE: begin
        if (head_vld) begin
          wvalid_o = {N_INIT_PORT{wvalid_i}} & head;
          wready_o = |(wready_i & head);
          pop      = wvalid_i & wready_o & wlast_i;
        end else if (handle_error_i) begin
          // Only enter DRAIN once every earlier burst has left the FIFO.
          state_n = DRAIN;
        end
      end
      DRAIN: begin
        wready_o = 1'b1;
        if (wvalid_i && wlast_i) begin
          wdata_error_completed_o = 1'b1;
          state_n                 = ROUTE;
        end
      end
      default: state_n = ROUTE;
    endcase
  end

endmodule

// File: tb/tb_axi_wdata_dest_router.sv
// Self-checking bench for axi_wdata_dest_router: directed steps followed by a random phase,
// every cycle compared against a queue-based reference model of the routing rules.
module tb_axi_wdata_dest_router;

  localparam int N = 8;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         push_dest_i;
  logic [N-1:0] dest_i;
  logic         grant_fifo_dest_o;
  logic         wvalid_i;
  logic         wlast_i;
  logic         wready_o;
  logic [N-1:0] wvalid_o;
  logic [N-1:0] wready_i;
  logic         handle_error_i;
  logic         wdata_error_completed_o;

  int total = 0;
  int bad   = 0;

  logic [N-1:0] mq[$];   // destinations the model holds, oldest first
  bit           mdrain;  // model is sinking an error burst
  bit           last_done;

  always #5 clk = ~clk;

  axi_wdata_dest_router #(
    .N_INIT_PORT (N),
    .FIFO_DEPTH  (D)
  ) dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .push_dest_i             (push_dest_i),
    .dest_i                  (dest_i),
    .grant_fifo_dest_o       (grant_fifo_dest_o),
    .wvalid_i                (wvalid_i),
    .wlast_i                 (wlast_i),
    .wready_o                (wready_o),
    .wvalid_o                (wvalid_o),
    .wready_i                (wready_i),
    .handle_error_i          (handle_error_i),
    .wdata_error_completed_o (wdata_error_completed_o)
  );

  function automatic logic [N-1:0] lowbit(input logic [N-1:0] v);
    logic [N-1:0] r;
    r = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (v[i]) begin
        r    = '0;
        r[i] = 1'b1;
      end
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_grant"},  32'(grant_fifo_dest_o), 32'(1));
    chk({tag, "_wready"}, 32'(wready_o), 32'(0));
    chk({tag, "_wvalid"}, 32'(wvalid_o), 32'(0));
    chk({tag, "_done"},   32'(wdata_error_completed_o), 32'(0));
  endtask

  task automatic idle_inputs();
    push_dest_i    = 1'b0;
    dest_i         = '0;
    wvalid_i       = 1'b0;
    wlast_i        = 1'b0;
    wready_i       = '0;
    handle_error_i = 1'b0;
  endtask

  // One clock: check outputs against the model mid-cycle, then advance the model.
  task automatic cycle();
    logic [N-1:0] head;
    logic [N-1:0] ev;
    logic         ok;
    logic         byp;
    logic         er;
    logic         ed;
    logic         pop;
    logic         acc;
    @(negedge clk);
    head = '0;
    ok   = 1'b0;
    byp  = 1'b0;
    if (!mdrain) begin
      if (mq.size() > 0) begin
        head = mq[0];
        ok   = 1'b1;
      end
`ifdef AXI_WDATA_DEST_BYPASS_EN
      else if (push_dest_i) begin
        head = lowbit(dest_i);
        ok   = 1'b1;
        byp  = 1'b1;
      end
`endif
    end
    ev = (ok && wvalid_i) ? head : '0;
    er = mdrain ? 1'b1 : (ok && ((wready_i & head) != '0));
    ed = mdrain && wvalid_i && wlast_i;
    chk("wvalid_o", 32'(wvalid_o), 32'(ev));
    chk("wready_o", 32'(wready_o), 32'(er));
    chk("grant",    32'(grant_fifo_dest_o), 32'(mq.size() < D));
    chk("done",     32'(wdata_error_completed_o), 32'(ed));
    pop = !mdrain && ok && wvalid_i && er && wlast_i;
    acc = push_dest_i && (mq.size() < D);
    if (!(byp && pop)) begin
      if (pop) void'(mq.pop_front());
      if (acc) mq.push_back(lowbit(dest_i));
    end
    if (mdrain) begin
      if (wvalid_i && wlast_i) mdrain = 1'b0;
    end else if (handle_error_i && !ok) begin
      mdrain = 1'b1;
    end
    last_done = ed;
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [N-1:0] d);
    push_dest_i = 1'b1;
    dest_i      = d;
    cycle();
    push_dest_i = 1'b0;
    dest_i      = '0;
  endtask

  task automatic burst(input int beats);
    wvalid_i = 1'b1;
    wready_i = '1;
    for (int b = 0; b < beats; b++) begin
      wlast_i = (b == beats - 1);
      cycle();
    end
    wvalid_i = 1'b0;
    wlast_i  = 1'b0;
  endtask

  initial begin
    idle_inputs();
    mdrain    = 1'b0;
    last_done = 1'b0;
    rst_n     = 1'b1;
    #1 rst_n  = 1'b0;
    #11;
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single port-2 burst of four beats.
    push_one(8'b0000_0100);
    burst(4);
    cycle();

    // Fill the FIFO, push once more while full, then pop one entry.
    push_one(8'h01);
    push_one(8'h02);
    push_one(8'h04);
    push_one(8'h08);
    push_one(8'h80);
    burst(1);
    cycle();
    burst(1);
    burst(1);
    burst(1);
    burst(1);

    // Multi-hot destination routes to its lowest port.
    push_one(8'b0000_0110);
    burst(2);

    // Error request held pending behind a queued burst, then a 3-beat drain.
    push_one(8'h10);
    handle_error_i = 1'b1;
    cycle();
    cycle();
    burst(2);
    cycle();
    burst(3);
    handle_error_i = 1'b0;
    cycle();

    // Port-5 burst with three stalled cycles on its first beat.
    push_one(8'h20);
    wvalid_i = 1'b1;
    wlast_i  = 1'b0;
    wready_i = 8'hDF;
    for (int s = 0; s < 3; s++) cycle();
    wready_i = '1;
    cycle();
    wlast_i = 1'b1;
    cycle();
    wvalid_i = 1'b0;
    wlast_i  = 1'b0;

    // Reset in the middle of a burst with further entries queued.
    push_one(8'h08);
    push_one(8'h01);
    push_one(8'h02);
    wvalid_i = 1'b1;
    wlast_i  = 1'b0;
    wready_i = '1;
    cycle();
    #2 rst_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    mq.delete();
    mdrain = 1'b0;
    idle_inputs();
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    wvalid_i = 1'b1;
    wlast_i  = 1'b1;
    wready_i = '1;
    cycle();
    wvalid_i = 1'b0;
    wlast_i  = 1'b0;

    // Push and single-beat last into an empty FIFO in one cycle.
    push_dest_i = 1'b1;
    dest_i      = 8'h40;
    wvalid_i    = 1'b1;
    wlast_i     = 1'b1;
    wready_i    = '1;
    cycle();
    push_dest_i = 1'b0;
    dest_i      = '0;
    cycle();
    wvalid_i = 1'b0;
    wlast_i  = 1'b0;
    cycle();

    // Random traffic; the decoder withholds pushes while an error is outstanding.
    for (int i = 0; i < 500; i++) begin
      wvalid_i = ($urandom_range(0, 3) != 0);
      wlast_i  = ($urandom_range(0, 2) == 0);
      wready_i = 8'($urandom) | 8'($urandom);
      if (handle_error_i) begin
        push_dest_i = 1'b0;
      end else begin
        push_dest_i = ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 29) == 0) handle_error_i = 1'b1;
      end
      dest_i = 8'($urandom_range(1, 255));
      cycle();
      if (last_done) handle_error_i = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
